// File: rtl/rgb_pwm_if.sv
// Signal bundle between the lights selector stage and the RGB PWM driver:
// colour/brightness/enable going in, LED drive and period marker coming out.
interface rgb_pwm_if;
  logic [23:0] light;
  logic [7:0]  brightness;
  logic        enable;
  logic        pwm_r;
  logic        pwm_g;
  logic        pwm_b;
  logic        period_start;

  modport master (
    output light, brightness, enable,
    input  pwm_r, pwm_g, pwm_b, period_start
  );

  modport slave (
    input  light, brightness, enable,
    output pwm_r, pwm_g, pwm_b, period_start
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver: 255-step period with a clk prescaler, per-channel
// duty = colour scaled by global brightness, reloaded only at period boundaries.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  rgb_pwm_if.slave bus
);

  localparam int unsigned          PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [7:0]           CNT_LAST = 8'd254;

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_r, duty_g, duty_b;
  logic [7:0]       duty_r_next, duty_g_next, duty_b_next;
  logic             pwm_r_q, pwm_g_q, pwm_b_q, period_start_q;
  logic             tick, wrap;

  // Brightness 255 maps to a x256 multiplier, so full colour at full brightness
  // yields duty 255 (always on); the low byte of the product is discarded.
  function automatic logic [7:0] scale(input logic [7:0] colour, input logic [7:0] bright);
    logic [15:0] prod;
    prod = 16'(colour) * (16'(bright) + 16'd1);
    return prod[15:8];
  endfunction

  always_comb begin
    duty_r_next = scale(bus.light[23:16], bus.brightness);
    duty_g_next = scale(bus.light[15:8],  bus.brightness);
    duty_b_next = scale(bus.light[7:0],   bus.brightness);
  end

  assign tick = bus.enable && (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == CNT_LAST);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt        <= '0;
      pwm_cnt        <= '0;
      duty_r         <= '0;
      duty_g         <= '0;
      duty_b         <= '0;
      pwm_r_q        <= 1'b0;
      pwm_g_q        <= 1'b0;
      pwm_b_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else if (!bus.enable) begin
      // Idle: counters parked at zero, duties track the inputs every clk so the
      // first period after enable uses the latest colour.
      pre_cnt        <= '0;
      pwm_cnt        <= '0;
      duty_r         <= duty_r_next;
      duty_g         <= duty_g_next;
      duty_b         <= duty_b_next;
      pwm_r_q        <= 1'b0;
      pwm_g_q        <= 1'b0;
      pwm_b_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) begin
        pwm_cnt <= wrap ? '0 : pwm_cnt + 8'd1;
      end
      // Duties only reload on the wrap so a mid-period colour change cannot glitch.
      if (wrap) begin
        duty_r <= duty_r_next;
        duty_g <= duty_g_next;
        duty_b <= duty_b_next;
      end
      pwm_r_q        <= (pwm_cnt < duty_r);
      pwm_g_q        <= (pwm_cnt < duty_g);
      pwm_b_q        <= (pwm_cnt < duty_b);
      period_start_q <= wrap;
    end
  end

  assign bus.pwm_r        = pwm_r_q;
  assign bus.pwm_g        = pwm_g_q;
  assign bus.pwm_b        = pwm_b_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: measures whole PWM periods (length, high time, contiguity)
// on a PRESCALE=4 and a PRESCALE=1 instance against duties computed from the colour rules.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  rgb_pwm_if bus0 ();
  rgb_pwm_if bus1 ();

  rgb_pwm_driver #(.PRESCALE(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rgb_pwm_driver #(.PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Reference: duty = colour * (brightness + 1) / 256, truncated.
  function automatic int model_duty(input logic [7:0] colour, input logic [7:0] bright);
    return (int'(colour) * (int'(bright) + 1)) / 256;
  endfunction

  function automatic logic [3:0] outs(input bit sel);
    if (sel) return {bus1.pwm_r, bus1.pwm_g, bus1.pwm_b, bus1.period_start};
    return {bus0.pwm_r, bus0.pwm_g, bus0.pwm_b, bus0.period_start};
  endfunction

  task automatic set_inputs(input bit sel, input logic [23:0] l, input logic [7:0] b);
    if (sel) begin
      bus1.light = l;
      bus1.brightness = b;
    end else begin
      bus0.light = l;
      bus0.brightness = b;
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Advance to the sample that shows a period_start pulse.
  task automatic sync_ps(input string tag, input bit sel);
    bit         found = 1'b0;
    int         k = 0;
    logic [3:0] o;
    while (!found && k < 1100) begin
      sample();
      k++;
      o = outs(sel);
      if (o[0]) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s sync: no period_start within %0d clks", tag, k);
    end
  endtask

  // Measure one period: from the sample after the current point up to and including
  // the next period_start sample. Optionally changes inputs part-way through.
  task automatic run_window(input string tag, input bit sel, input int div,
                            input logic [23:0] exp_light, input logic [7:0] exp_bright,
                            input int change_at, input logic [23:0] new_light,
                            input logic [7:0] new_bright);
    int         hr = 0, hg = 0, hb = 0, len = 0;
    bit         lr = 0, lg = 0, lb = 0, contig = 1, done = 0;
    int         er, eg, eb;
    logic [3:0] o;
    er = model_duty(exp_light[23:16], exp_bright);
    eg = model_duty(exp_light[15:8],  exp_bright);
    eb = model_duty(exp_light[7:0],   exp_bright);
    while (!done && len < 2 * 255 * div + 10) begin
      sample();
      len++;
      o = outs(sel);
      if (o[3]) begin hr++; if (lr) contig = 0; end else lr = 1;
      if (o[2]) begin hg++; if (lg) contig = 0; end else lg = 1;
      if (o[1]) begin hb++; if (lb) contig = 0; end else lb = 1;
      if (o[0]) done = 1;
      else if (len == change_at) begin
        @(negedge clk);
        set_inputs(sel, new_light, new_bright);
      end
    end
    n_checks++;
    if (len !== 255 * div) begin
      n_fail++;
      $display("FAIL %s period_len: got %0d clks, want %0d", tag, len, 255 * div);
    end
    n_checks++;
    if (hr !== er * div) begin
      n_fail++;
      $display("FAIL %s high_r: got %0d clks, want %0d", tag, hr, er * div);
    end
    n_checks++;
    if (hg !== eg * div) begin
      n_fail++;
      $display("FAIL %s high_g: got %0d clks, want %0d", tag, hg, eg * div);
    end
    n_checks++;
    if (hb !== eb * div) begin
      n_fail++;
      $display("FAIL %s high_b: got %0d clks, want %0d", tag, hb, eb * div);
    end
    n_checks++;
    if (contig !== 1'b1) begin
      n_fail++;
      $display("FAIL %s contiguous: got %0b, want 1 (high time must start at period start)", tag, contig);
    end
  endtask

  task automatic test_reset();
    logic [3:0] o0, o1;
    rst_n = 1'b0;
    bus0.enable = 1'b1;
    bus1.enable = 1'b1;
    set_inputs(0, 24'hFFFFFF, 8'hFF);
    set_inputs(1, 24'hFFFFFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      sample();
      o0 = outs(0);
      o1 = outs(1);
      n_checks++;
      if ({o0, o1} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b, want 00000000", {o0, o1});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First period out of reset runs on the cleared duties.
    run_window("reset_first_period", 0, 4, 24'h000000, 8'h00, -1, 24'h0, 8'h0);
    run_window("reset_second_period", 0, 4, 24'hFFFFFF, 8'hFF, -1, 24'h0, 8'h0);
  endtask

  task automatic test_full_blue();
    logic [3:0] o;
    @(negedge clk);
    bus0.enable = 1'b0;
    set_inputs(0, 24'h0000FF, 8'hFF);
    sample();
    o = outs(0);
    n_checks++;
    if (o !== 4'b0000) begin
      n_fail++;
      $display("FAIL disable_outputs: got %b, want 0000", o);
    end
    repeat (3) @(negedge clk);
    bus0.enable = 1'b1;
    run_window("blue_first", 0, 4, 24'h0000FF, 8'hFF, -1, 24'h0, 8'h0);
    run_window("blue_second", 0, 4, 24'h0000FF, 8'hFF, -1, 24'h0, 8'h0);
  endtask

  task automatic test_half_red_midperiod();
    @(negedge clk);
    set_inputs(0, 24'h800000, 8'hFF);
    sync_ps("half_red", 0);
    run_window("half_red", 0, 4, 24'h800000, 8'hFF, -1, 24'h0, 8'h0);
    run_window("mid_change_old", 0, 4, 24'h800000, 8'hFF, 300, 24'h400000, 8'hFF);
    run_window("mid_change_new", 0, 4, 24'h400000, 8'hFF, -1, 24'h0, 8'h0);
  endtask

  task automatic test_brightness();
    @(negedge clk);
    set_inputs(0, 24'hFF0000, 8'h7F);
    sync_ps("bright", 0);
    run_window("bright_7f", 0, 4, 24'hFF0000, 8'h7F, 500, 24'hFF0000, 8'h00);
    run_window("bright_00", 0, 4, 24'hFF0000, 8'h00, -1, 24'h0, 8'h0);
  endtask

  task automatic test_enable_off();
    logic [3:0] o;
    @(negedge clk);
    set_inputs(0, 24'hFF0000, 8'hFF);
    sync_ps("enable_off", 0);
    repeat (50) sample();
    o = outs(0);
    n_checks++;
    if (o[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_off_pre: got pwm_r=%b, want 1", o[3]);
    end
    @(negedge clk);
    bus0.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      o = outs(0);
      n_checks++;
      if (o !== 4'b0000) begin
        n_fail++;
        $display("FAIL enable_off_outputs: got %b at clk %0d, want 0000", o, i);
      end
      if (i == 10) begin
        @(negedge clk);
        set_inputs(0, 24'h00FF00, 8'hFF);
      end
    end
    @(negedge clk);
    bus0.enable = 1'b1;
    run_window("reenable_first", 0, 4, 24'h00FF00, 8'hFF, -1, 24'h0, 8'h0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] o;
    @(negedge clk);
    set_inputs(0, 24'hFF0000, 8'hFF);
    sync_ps("reset_mid", 0);
    repeat (100) sample();
    o = outs(0);
    n_checks++;
    if (o[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got pwm_r=%b, want 1", o[3]);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    o = outs(0);
    n_checks++;
    if (o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b without clk edge, want 0000", o);
    end
    repeat (5) sample();
    o = outs(0);
    n_checks++;
    if (o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got %b, want 0000", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_window("reset_mid_first", 0, 4, 24'h000000, 8'h00, -1, 24'h0, 8'h0);
    run_window("reset_mid_second", 0, 4, 24'hFF0000, 8'hFF, -1, 24'h0, 8'h0);
  endtask

  task automatic test_prescale1();
    @(negedge clk);
    set_inputs(1, 24'h8040C0, 8'hFF);
    sync_ps("pre1", 1);
    run_window("pre1_mixed", 1, 1, 24'h8040C0, 8'hFF, 100, 24'hFFFFFF, 8'hFF);
    run_window("pre1_full", 1, 1, 24'hFFFFFF, 8'hFF, -1, 24'h0, 8'h0);
  endtask

  task automatic test_random(input bit sel, input int div, input int n);
    logic [23:0] cur_l, nxt_l;
    logic [7:0]  cur_b, nxt_b;
    cur_l = 24'($urandom);
    cur_b = 8'($urandom);
    @(negedge clk);
    set_inputs(sel, cur_l, cur_b);
    sync_ps("random", sel);
    for (int i = 0; i < n; i++) begin
      nxt_l = 24'($urandom);
      nxt_b = 8'($urandom);
      run_window($sformatf("random_%0d_%0d", sel, i), sel, div, cur_l, cur_b,
                 $urandom_range(1, 250 * div - 5), nxt_l, nxt_b);
      cur_l = nxt_l;
      cur_b = nxt_b;
    end
  endtask

  initial begin
    test_reset();
    test_full_blue();
    test_half_red_midperiod();
    test_brightness();
    test_enable_off();
    test_reset_mid();
    test_prescale1();
    test_random(0, 4, 6);
    test_random(1, 1, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
